// File: rtl/fpcvt_sample_loader_if.sv
// Sample-loader bus: serial bit stream in, parallel sample handshake out.
// master = serial source / sample consumer side, slave = the loader itself.
interface fpcvt_sample_loader_if #(
  parameter int W = 12
);
  logic         ser_in;
  logic         ser_valid;
  logic         frame;
  logic [W-1:0] d_out;
  logic         d_valid;
  logic         d_ready;
  logic         overrun;
  logic         frame_err;
  logic [7:0]   word_count;

  modport master (
    output ser_in, ser_valid, frame, d_ready,
    input  d_out, d_valid, overrun, frame_err, word_count
  );

  modport slave (
    input  ser_in, ser_valid, frame, d_ready,
    output d_out, d_valid, overrun, frame_err, word_count
  );
endinterface

// File: rtl/fpcvt_sample_loader.sv
// Serial-to-parallel front end for the floating-point converter.
// Stage p0 assembles MSB-first bits into W-bit samples; stage p1 is a small
// FIFO whose head is mirrored into registered d_out/d_valid. The output
// registers always reflect the FIFO state after the current edge's pop and
// push, so a completed sample is visible the cycle after its last bit, and a
// popped entry is replaced by the next one without a bubble.
module fpcvt_sample_loader #(
  parameter int W     = 12,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  fpcvt_sample_loader_if.slave     bus
);

  localparam int BIT_W  = $clog2(W + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Stage p0: assembly state. The shift register holds only the first W-1
  // bits; the W-th bit joins them combinationally on completion.
  state_t                  state_p0;
  logic [BIT_W-1:0]        bit_cnt_p0;
  logic signed [W-2:0]     shreg_p0;
  logic                    frame_err_p0;

  logic                    sample_done;
  logic signed [W-1:0]     sample_word;

  // Stage p1: FIFO storage, pointers and registered outputs.
  logic signed [W-1:0]     mem_p1 [DEPTH];
  logic [PTR_W-1:0]        rd_ptr_p1;
  logic [PTR_W-1:0]        wr_ptr_p1;
  logic [FILL_W-1:0]       fill_p1;
  logic signed [W-1:0]     d_out_p1;
  logic                    vld_p1;
  logic                    overrun_p1;
  logic [7:0]              word_count_p1;

  logic                    pop;
  logic                    full;
  logic                    accept;
  logic                    drop;
  logic [FILL_W-1:0]       fill_after_pop;
  logic [FILL_W-1:0]       fill_next;
  logic [PTR_W-1:0]        rd_ptr_next;
  logic signed [W-1:0]     head_next;

  // Completion detect: W-th non-frame bit while shifting.
  always_comb begin
    sample_done = (state_p0 == SHIFT) && bus.ser_valid && !bus.frame &&
                  (bit_cnt_p0 == BIT_W'(W - 1));
    sample_word = $signed({shreg_p0, bus.ser_in});
  end

  // Framing FSM: a frame bit always starts a new sample; one that interrupts
  // a partial sample flags frame_err for a single cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0     <= IDLE;
      bit_cnt_p0   <= '0;
      shreg_p0     <= '0;
      frame_err_p0 <= 1'b0;
    end else begin
      frame_err_p0 <= 1'b0;
      if (bus.ser_valid) begin
        if (bus.frame) begin
          frame_err_p0 <= (state_p0 == SHIFT);
          shreg_p0     <= $signed({{(W-2){1'b0}}, bus.ser_in});
          bit_cnt_p0   <= BIT_W'(1);
          state_p0     <= SHIFT;
        end else if (state_p0 == SHIFT) begin
          shreg_p0 <= $signed({shreg_p0[W-3:0], bus.ser_in});
          if (bit_cnt_p0 == BIT_W'(W - 1)) begin
            bit_cnt_p0 <= '0;
            state_p0   <= IDLE;
          end else begin
            bit_cnt_p0 <= bit_cnt_p0 + 1'b1;
          end
        end
      end
    end
  end

  // FIFO next-state: a pop frees a slot in the same cycle, so a full FIFO
  // with a simultaneous pop still accepts the new sample.
  always_comb begin
    pop            = vld_p1 && bus.d_ready;
    full           = (fill_p1 == FILL_W'(DEPTH));
    accept         = sample_done && (!full || pop);
    drop           = sample_done && full && !pop;
    fill_after_pop = fill_p1 - FILL_W'(pop);
    fill_next      = fill_after_pop + FILL_W'(accept);
    rd_ptr_next    = rd_ptr_p1 + PTR_W'(pop);
    head_next      = (fill_after_pop == '0) ? sample_word : mem_p1[rd_ptr_next];
  end

  // FIFO storage write; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_p1[wr_ptr_p1] <= sample_word;
    end
  end

  // FIFO control and registered head: d_out holds its last value when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_p1     <= '0;
      wr_ptr_p1     <= '0;
      fill_p1       <= '0;
      vld_p1        <= 1'b0;
      d_out_p1      <= '0;
      overrun_p1    <= 1'b0;
      word_count_p1 <= '0;
    end else begin
      rd_ptr_p1 <= rd_ptr_next;
      fill_p1   <= fill_next;
      vld_p1    <= (fill_next != '0);
      if (fill_next != '0) begin
        d_out_p1 <= head_next;
      end
      if (accept) begin
        wr_ptr_p1     <= wr_ptr_p1 + 1'b1;
        word_count_p1 <= word_count_p1 + 8'd1;
      end
      if (drop) begin
        overrun_p1 <= 1'b1;
      end
    end
  end

  assign bus.d_out      = d_out_p1;
  assign bus.d_valid    = vld_p1;
  assign bus.overrun    = overrun_p1;
  assign bus.frame_err  = frame_err_p0;
  assign bus.word_count = word_count_p1;

endmodule

// File: tb/tb_fpcvt_sample_loader.sv
// Bench for fpcvt_sample_loader: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue-based
// model of the sample stream.
module tb_fpcvt_sample_loader;
  localparam int W     = 12;
  localparam int DEPTH = 2;

  logic clk;
  logic rst;

  fpcvt_sample_loader_if #(.W(W)) bus ();

  fpcvt_sample_loader #(.W(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Reference model: collected-bit count, accumulated value, queue of samples.
  int m_q[$];
  int m_nbits;
  int m_acc;
  bit m_ovr;
  bit m_ferr;
  int m_wc;
  int m_last;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_step();
    bit pop;
    bit push;
    int val;
    pop  = 0;
    push = 0;
    val  = 0;
    if (rst) begin
      m_q.delete();
      m_nbits = 0;
      m_acc   = 0;
      m_ovr   = 0;
      m_ferr  = 0;
      m_wc    = 0;
      m_last  = 0;
    end else begin
      m_ferr = 0;
      pop = (m_q.size() > 0) && (bus.d_ready === 1'b1);
      if (bus.ser_valid) begin
        if (bus.frame) begin
          if (m_nbits > 0) m_ferr = 1;
          m_acc   = int'(bus.ser_in);
          m_nbits = 1;
        end else if (m_nbits > 0) begin
          m_acc   = m_acc * 2 + int'(bus.ser_in);
          m_nbits = m_nbits + 1;
          if (m_nbits == W) begin
            push    = 1;
            val     = m_acc & ((1 << W) - 1);
            m_nbits = 0;
          end
        end
      end
      if (push && m_q.size() == DEPTH && !pop) begin
        m_ovr = 1;
        push  = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(val);
        m_wc = (m_wc + 1) % 256;
      end
      if (m_q.size() > 0) m_last = m_q[0];
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cmp_d_valid", 32'(bus.d_valid), 32'(m_q.size() > 0));
        chk("cmp_d_out", 32'(bus.d_out), m_last);
        chk("cmp_overrun", 32'(bus.overrun), 32'(m_ovr));
        chk("cmp_frame_err", 32'(bus.frame_err), 32'(m_ferr));
        chk("cmp_word_count", 32'(bus.word_count), m_wc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic send_bit(input logic b, input logic f);
    bus.ser_valid = 1;
    bus.ser_in    = b;
    bus.frame     = f;
    tick();
    bus.ser_valid = 0;
    bus.frame     = 0;
    bus.ser_in    = 0;
  endtask

  // Sends a full sample MSB-first; optionally raises d_ready only on the last bit.
  task automatic send_word(input int v, input int gap, input bit rdy_last);
    for (int b = W - 1; b >= 0; b--) begin
      if (b == 0 && rdy_last) bus.d_ready = 1;
      send_bit(logic'((v >> b) & 1), logic'(b == W - 1));
      if (b == 0 && rdy_last) bus.d_ready = 0;
      if (b > 0) repeat (gap) tick();
    end
  endtask

  task automatic drain();
    bus.d_ready = 1;
    repeat (DEPTH + 1) tick();
    bus.d_ready = 0;
  endtask

  initial begin
    rst           = 1;
    bus.ser_in    = 0;
    bus.ser_valid = 0;
    bus.frame     = 0;
    bus.d_ready   = 0;
    tick();
    tick();
    rst    = 0;
    chk_en = 1;

    chk("reset_d_valid", 32'(bus.d_valid), 0);
    chk("reset_d_out", 32'(bus.d_out), 0);
    chk("reset_overrun", 32'(bus.overrun), 0);
    chk("reset_word_count", 32'(bus.word_count), 0);

    // Single sample, held while not ready.
    send_word(35, 0, 0);
    chk("single_valid", 32'(bus.d_valid), 1);
    chk("single_d_out", 32'(bus.d_out), 32'h023);
    chk("single_word_count", 32'(bus.word_count), 1);
    repeat (3) tick();
    chk("single_hold", 32'(bus.d_out), 32'h023);
    bus.d_ready = 1;
    tick();
    bus.d_ready = 0;
    chk("single_drained", 32'(bus.d_valid), 0);
    chk("single_d_out_kept", 32'(bus.d_out), 32'h023);

    // Negative sample with gaps between bits.
    send_word(32'hFED, 3, 0);
    chk("neg_valid", 32'(bus.d_valid), 1);
    chk("neg_d_out", 32'(bus.d_out), 32'hFED);
    chk("neg_frame_err", 32'(bus.frame_err), 0);
    drain();

    // Overrun: third sample dropped.
    do_reset();
    send_word(5, 0, 0);
    send_word(35, 0, 0);
    send_word(32'hFED, 0, 0);
    chk("ovr_overrun", 32'(bus.overrun), 1);
    chk("ovr_word_count", 32'(bus.word_count), 2);
    chk("ovr_head", 32'(bus.d_out), 5);
    bus.d_ready = 1;
    tick();
    chk("ovr_second", 32'(bus.d_out), 35);
    chk("ovr_second_valid", 32'(bus.d_valid), 1);
    tick();
    chk("ovr_empty", 32'(bus.d_valid), 0);
    bus.d_ready = 0;

    // Full FIFO, push and pop on the same edge.
    do_reset();
    send_word(5, 0, 0);
    send_word(35, 0, 0);
    send_word(32'hFED, 0, 1);
    chk("fullpop_overrun", 32'(bus.overrun), 0);
    chk("fullpop_word_count", 32'(bus.word_count), 3);
    chk("fullpop_head", 32'(bus.d_out), 35);
    bus.d_ready = 1;
    tick();
    chk("fullpop_third", 32'(bus.d_out), 32'hFED);
    tick();
    chk("fullpop_empty", 32'(bus.d_valid), 0);
    bus.d_ready = 0;

    // Early frame on the 7th bit.
    do_reset();
    send_bit(1, 1);
    for (int i = 0; i < 5; i++) send_bit(1, 0);
    send_bit(1, 1);
    chk("early_ferr_pulse", 32'(bus.frame_err), 1);
    send_bit(0, 0);
    chk("early_ferr_clear", 32'(bus.frame_err), 0);
    for (int i = 0; i < W - 2; i++) send_bit(0, 0);
    chk("early_d_out", 32'(bus.d_out), 32'h800);
    chk("early_word_count", 32'(bus.word_count), 1);
    drain();

    // Reset in the middle of assembly with a sample queued.
    do_reset();
    send_word(5, 0, 0);
    for (int b = W - 1; b >= W - 6; b--) send_bit(logic'((35 >> b) & 1), logic'(b == W - 1));
    do_reset();
    chk("midrst_valid", 32'(bus.d_valid), 0);
    chk("midrst_d_out", 32'(bus.d_out), 0);
    chk("midrst_overrun", 32'(bus.overrun), 0);
    chk("midrst_word_count", 32'(bus.word_count), 0);
    send_word(5, 0, 0);
    chk("midrst_fresh", 32'(bus.d_out), 5);
    drain();

    // Randomized stream: aligned frames, occasional early frames, gaps,
    // random consumer back-pressure and rare resets.
    for (int i = 0; i < 4000; i++) begin
      bit sv;
      sv            = ($urandom_range(0, 3) != 0);
      bus.ser_valid = sv;
      bus.ser_in    = logic'($urandom_range(0, 1));
      bus.frame     = sv && ((m_nbits == 0 && $urandom_range(0, 1) == 1) ||
                             $urandom_range(0, 40) == 0);
      if (i % 500 < 250) bus.d_ready = ($urandom_range(0, 3) == 0);
      else               bus.d_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 700) == 0);
      tick();
    end
    rst           = 0;
    bus.ser_valid = 0;
    bus.frame     = 0;
    drain();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpcvt_sample_loader.md
# fpcvt_sample_loader

Serial-to-parallel front end for the floating-point converter. Assembles MSB-first serial bits into 12-bit two's-complement samples, buffers completed samples in a small FIFO, and presents them on `d_out` with a valid/ready handshake. `d_out` drives the converter's `D` input directly. The downstream capture logic asserts `d_ready` once it has registered the converter's S/E/F result.

## Interface
- `W`, 12: sample width; must equal the converter's `D` width.
- `DEPTH`, 2: FIFO entries; power of two, at least 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `ser_in` in 1: serial data bit, MSB first.
- `ser_valid` in 1: `ser_in` is sampled on cycles where this is 1.
- `frame` in 1: qualified by `ser_valid`; marks the current bit as the MSB of a new sample.
- `d_out` out W: head-of-FIFO sample, two's complement.
- `d_valid` out 1: `d_out` holds a valid sample.
- `d_ready` in 1: consumer accepts `d_out` on a cycle with `d_valid && d_ready`.
- `overrun` out 1: sticky; set when a completed sample is dropped because the FIFO is full.
- `frame_err` out 1: one-cycle pulse when `frame` arrives before the current sample is complete.
- `word_count` out 8: count of samples pushed into the FIFO; wraps 255→0.

## Operation
- **Reset values:** state IDLE, bit counter 0, shift register 0, FIFO empty, `d_out`=0, `d_valid`=0, `overrun`=0, `frame_err`=0, `word_count`=0. Reset has priority over every other event, including a sample mid-assembly or a handshake in progress.
- **IDLE state**
  - `ser_valid && !frame`: ignored.
  - `ser_valid && frame`: shift `ser_in` into bit W-1, set counter to 1, go to SHIFT.
- **SHIFT state**
  - Each `ser_valid && !frame` shifts in one bit and increments the counter.
  - When the W-th bit arrives, the assembled sample is complete: push it to the FIFO, clear the counter, return to IDLE.
  - `ser_valid && frame` before the W-th bit: pulse `frame_err`, discard the partial sample, and treat this bit as the MSB of a new sample (counter=1, stay in SHIFT).
  - Cycles with `ser_valid`=0 hold all state; there is no timeout.
- **FIFO**
  - Push on sample completion; pop on `d_valid && d_ready`.
  - Full, push and pop in the same cycle: both happen, the push is accepted and `overrun` is not set.
  - Full, push without pop: the sample is dropped, `overrun` is set and stays set until `rst`, and `word_count` does not increment.
  - Empty, push and pop in the same cycle: the pop has no effect (`d_valid` was 0); the push is stored.
- **Output**
  - `d_out` and `d_valid` are registered from the FIFO head.
  - `d_out` is stable while `d_valid && !d_ready`.
  - `d_out` keeps its last value when the FIFO is empty (`d_valid`=0).
- **Arithmetic:** the data path does no sign processing; bits pass through unchanged. Counters wrap modulo their width.

## Timing
- **Latency:** the W-th `ser_valid` at edge N gives the push at edge N. With an empty FIFO, `d_valid`=1 and `d_out`=sample from edge N+1. Minimum serial-to-output latency is W+1 cycles from the MSB.
- **Throughput:** one sample per W `ser_valid` cycles. Back-to-back frames are allowed: the cycle after completion may carry the next `frame` bit.
- **Handshake:** after a pop at edge M, the next entry (if any) appears on `d_out` at edge M+1, with no bubble. `d_valid` deasserts at M+1 if the FIFO becomes empty.
- **`frame_err` timing:** asserted for exactly the cycle after the offending `ser_valid` edge.
- **`word_count` timing:** updated on the same edge as an accepted push.

## Test plan
- **Single sample:** reset, then send 12'd35 (000000100011) MSB-first with `frame` on bit 1 and `d_ready`=0 → `d_valid`=1 with `d_out`=12'h023 on cycle 13, held stable; `word_count`=1.
- **Negative sample with stall:** send 12'hFED (−19) with `ser_valid` gaps of 3 cycles between bits → `d_out`=12'hFED, `d_valid`=1 one cycle after the last bit; `frame_err`=0.
- **Overrun:** with `d_ready`=0, send 12'd5, 12'd35, 12'hFED → the FIFO holds 5 then 35; `overrun`=1 after the third sample; `word_count`=2. Raising `d_ready` yields 5, then 35, then `d_valid`=0.
- **Full push with simultaneous pop:** FIFO full (5, 35) and `d_ready`=1 on the cycle the third sample completes → `overrun` stays 0; output order is 5, 35, 12'hFED; `word_count`=3.
- **Early frame:** assert `frame` on the 7th bit of a sample → `frame_err` pulses one cycle; the next 12 bits (12'h800) produce `d_out`=12'h800; the partial sample never appears.
- **Reset mid-operation:** assert `rst` after 6 bits with one sample queued → the next cycle shows `d_valid`=0, `d_out`=0, `overrun`=0, `word_count`=0. A following fresh 12-bit frame of 12'd5 outputs 12'd5.
